// File: rtl/strum_match_gen.sv
// Strum front end: synchronises the raw strum button and fret selector, debounces,
// emits one timestamped match event per strum and rejects out-of-range frets.
module strum_match_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 65000,
  parameter int unsigned RELEASE_CYCLES  = 65000,
  parameter int unsigned CNT_W           = 17,
  parameter int unsigned MAX_FRET        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] song_time,
  input  logic        song_running,
  input  logic        strum_raw,
  input  logic [4:0]  fret_raw,
  output logic        match_en,
  output logic [4:0]  fret,
  output logic [15:0] match_time,
  output logic        reject,
  output logic [7:0]  strum_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DEB_L  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] REL_L  = CNT_W'(RELEASE_CYCLES);
  localparam logic [4:0]       FMAX_L = 5'(MAX_FRET);

  logic             strum_m_q, strum_s_q;
  logic [4:0]       fret_m_q, fret_s_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [15:0]      onset_q;
  logic             match_en_q, reject_q;
  logic [4:0]       fret_q;
  logic [15:0]      match_time_q;
  logic [7:0]       strum_count_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strum_m_q <= 1'b0;
      strum_s_q <= 1'b0;
      fret_m_q  <= '0;
      fret_s_q  <= '0;
    end else begin
      strum_m_q <= strum_raw;
      strum_s_q <= strum_m_q;
      fret_m_q  <= fret_raw;
      fret_s_q  <= fret_m_q;
    end
  end

  // The counter already holds 1 on the first DEBOUNCE cycle, so the compare uses
  // the incremented value: the exit fires after exactly N consecutive synced samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_RELEASE;
      cnt_q         <= '0;
      onset_q       <= '0;
      match_en_q    <= 1'b0;
      reject_q      <= 1'b0;
      fret_q        <= '0;
      match_time_q  <= '0;
      strum_count_q <= '0;
    end else begin
      match_en_q <= 1'b0;
      reject_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (strum_s_q) begin
            if (song_running) begin
              onset_q <= song_time;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_DEBOUNCE;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_WAIT_RELEASE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!strum_s_q) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (!song_running) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_RELEASE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == DEB_L) state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (fret_s_q <= FMAX_L) begin
            match_en_q    <= 1'b1;
            fret_q        <= fret_s_q;
            match_time_q  <= onset_q;
            strum_count_q <= strum_count_q + 8'd1;
          end else begin
            reject_q <= 1'b1;
          end
          cnt_q   <= '0;
          state_q <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (strum_s_q) begin
            cnt_q <= '0;
          end else if (cnt_d == REL_L) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_RELEASE;
        end
      endcase
    end
  end

  assign match_en    = match_en_q;
  assign reject      = reject_q;
  assign fret        = fret_q;
  assign match_time  = match_time_q;
  assign strum_count = strum_count_q;

endmodule

// File: tb/tb_strum_match_gen.sv
// Directed bench for strum_match_gen with short debounce/release windows (4/4).
module tb_strum_match_gen;

  logic        clk;
  logic        rst_n;
  logic [15:0] song_time;
  logic        song_running;
  logic        strum_raw;
  logic [4:0]  fret_raw;
  logic        match_en;
  logic [4:0]  fret;
  logic [15:0] match_time;
  logic        reject;
  logic [7:0]  strum_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ev_cnt = 0;
  int rej_cnt = 0;
  int viol_cnt = 0;
  logic prev_pulse = 1'b0;

  strum_match_gen #(
    .DEBOUNCE_CYCLES(4),
    .RELEASE_CYCLES (4),
    .CNT_W          (17),
    .MAX_FRET       (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .song_time   (song_time),
    .song_running(song_running),
    .strum_raw   (strum_raw),
    .fret_raw    (fret_raw),
    .match_en    (match_en),
    .fret        (fret),
    .match_time  (match_time),
    .reject      (reject),
    .strum_count (strum_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (match_en === 1'b1) ev_cnt++;
    if (reject === 1'b1) rej_cnt++;
    if (match_en === 1'b1 && reject === 1'b1) viol_cnt++;
    if ((match_en === 1'b1 || reject === 1'b1) && prev_pulse) viol_cnt++;
    prev_pulse = (match_en === 1'b1) || (reject === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_match_en"}, 32'(match_en), 0);
    chk({tag, "_reject"}, 32'(reject), 0);
    chk({tag, "_fret"}, 32'(fret), 0);
    chk({tag, "_match_time"}, 32'(match_time), 0);
    chk({tag, "_strum_count"}, 32'(strum_count), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    song_time = 16'd0;
    song_running = 1'b1;
    strum_raw = 1'b0;
    fret_raw = 5'd7;
    tick(2);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick(10);

    // 1: clean strum, timestamp taken at synced onset
    song_time = 16'd1234;
    strum_raw = 1'b1;
    tick(3);
    song_time = 16'd5555;
    tick(3);
    chk("t1_no_early_match", 32'(match_en), 0);
    tick(1);
    chk("t1_match_at_7", 32'(match_en), 1);
    chk("t1_fret", 32'(fret), 7);
    chk("t1_match_time", 32'(match_time), 1234);
    chk("t1_count", 32'(strum_count), 1);
    tick(1);
    chk("t1_single_pulse", 32'(match_en), 0);
    tick(12);
    strum_raw = 1'b0;
    tick(8);
    chk("t1_events", 32'(ev_cnt), 1);

    // 2: bounce then clean hold
    strum_raw = 1'b1; tick(2);
    strum_raw = 1'b0; tick(1);
    strum_raw = 1'b1; tick(2);
    strum_raw = 1'b0; tick(6);
    chk("t2_bounce_no_event", 32'(ev_cnt), 1);
    chk("t2_bounce_no_reject", 32'(rej_cnt), 0);
    fret_raw = 5'd3;
    song_time = 16'd300;
    strum_raw = 1'b1; tick(10);
    chk("t2_events", 32'(ev_cnt), 2);
    chk("t2_count", 32'(strum_count), 2);
    chk("t2_fret", 32'(fret), 3);
    chk("t2_match_time", 32'(match_time), 300);
    strum_raw = 1'b0; tick(8);

    // 3: long hold, short release, adequate release
    fret_raw = 5'd10;
    song_time = 16'd400;
    strum_raw = 1'b1; tick(50);
    chk("t3_hold_one_event", 32'(ev_cnt), 3);
    chk("t3_hold_count", 32'(strum_count), 3);
    strum_raw = 1'b0; tick(2);
    song_time = 16'd450;
    strum_raw = 1'b1; tick(20);
    chk("t3_short_release_no_event", 32'(ev_cnt), 3);
    strum_raw = 1'b0; tick(6);
    fret_raw = 5'd12;
    song_time = 16'd500;
    strum_raw = 1'b1; tick(10);
    chk("t3_restrum_event", 32'(ev_cnt), 4);
    chk("t3_restrum_count", 32'(strum_count), 4);
    chk("t3_restrum_fret", 32'(fret), 12);
    chk("t3_restrum_time", 32'(match_time), 500);
    strum_raw = 1'b0; tick(8);

    // 4: fret above range is rejected, outputs held
    fret_raw = 5'd30;
    song_time = 16'd600;
    strum_raw = 1'b1; tick(6);
    chk("t4_no_early_reject", 32'(reject), 0);
    tick(1);
    chk("t4_reject", 32'(reject), 1);
    chk("t4_no_match", 32'(match_en), 0);
    chk("t4_fret_held", 32'(fret), 12);
    chk("t4_time_held", 32'(match_time), 500);
    chk("t4_count_held", 32'(strum_count), 4);
    tick(1);
    chk("t4_reject_single", 32'(reject), 0);
    strum_raw = 1'b0; tick(8);
    chk("t4_reject_total", 32'(rej_cnt), 1);

    // 5: song gating
    fret_raw = 5'd5;
    song_running = 1'b0;
    strum_raw = 1'b1; tick(10);
    strum_raw = 1'b0; tick(8);
    chk("t5_stopped_no_event", 32'(ev_cnt), 4);
    song_running = 1'b1;
    strum_raw = 1'b1; tick(4);
    song_running = 1'b0; tick(4);
    song_running = 1'b1; tick(10);
    chk("t5_abort_no_event", 32'(ev_cnt), 4);
    chk("t5_abort_no_reject", 32'(rej_cnt), 1);
    strum_raw = 1'b0; tick(8);
    fret_raw = 5'd24;
    song_time = 16'd700;
    strum_raw = 1'b1; tick(10);
    chk("t5_maxfret_event", 32'(ev_cnt), 5);
    chk("t5_maxfret_fret", 32'(fret), 24);
    chk("t5_maxfret_time", 32'(match_time), 700);
    chk("t5_maxfret_count", 32'(strum_count), 5);
    strum_raw = 1'b0; tick(8);

    // 6: reset during debounce
    fret_raw = 5'd9;
    song_time = 16'd750;
    strum_raw = 1'b1; tick(5);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("t6_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(20);
    chk("t6_held_no_event", 32'(ev_cnt), 5);
    chk("t6_count_zero", 32'(strum_count), 0);
    strum_raw = 1'b0; tick(2);
    strum_raw = 1'b1; tick(10);
    chk("t6_short_release_no_event", 32'(ev_cnt), 5);
    strum_raw = 1'b0; tick(6);
    song_time = 16'd800;
    strum_raw = 1'b1; tick(10);
    chk("t6_new_event", 32'(ev_cnt), 6);
    chk("t6_count", 32'(strum_count), 1);
    chk("t6_fret", 32'(fret), 9);
    chk("t6_time", 32'(match_time), 800);
    strum_raw = 1'b0; tick(8);

    chk("pulse_rules", 32'(viol_cnt), 0);
    chk("total_rejects", 32'(rej_cnt), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/strum_match_gen.md
Name: strum_match_gen

Overview:
- Player-input front end: turns the raw guitar-controller strum button and fret selector into clean, timestamped match events.
- Produces the `match_en`/`fret`/`match_time` triple consumed by each string display/judge block.
- Handles synchronisation, debounce, single-event-per-strum, timestamping against `song_time`, and fret-range validation.
- One instance per string, clocked in the 65 MHz video domain.

Parameters:
- DEBOUNCE_CYCLES, 65000: consecutive synced-high cycles before a strum is accepted (1 ms at 65 MHz).
- RELEASE_CYCLES, 65000: consecutive synced-low cycles before a new strum can arm.
- CNT_W, 17: debounce counter width; must hold max(DEBOUNCE_CYCLES, RELEASE_CYCLES).
- MAX_FRET, 24: highest legal fret number; larger values are rejected.

Ports:
- clk  in  1  system clock (65 MHz).
- rst_n  in  1  asynchronous active-low reset.
- song_time  in  16  current song time, same units as note times.
- song_running  in  1  high while the song plays; events are suppressed when low.
- strum_raw  in  1  raw strum button, asynchronous, bouncy, active-high.
- fret_raw  in  5  raw fret selector, asynchronous.
- match_en  out  1  one-cycle pulse: valid strum event.
- fret  out  5  fret of the last event; held between pulses.
- match_time  out  16  song_time at strum onset; held between pulses.
- reject  out  1  one-cycle pulse: strum debounced but fret > MAX_FRET.
- strum_count  out  8  count of accepted events, wraps 255->0.

Behaviour:
- Reset (async assert, sync release):
  - FSM -> WAIT_RELEASE with counter 0.
  - match_en, reject, fret, match_time, strum_count all 0.
  - Sync flops are cleared.
- Synchronisers: strum_raw and fret_raw each pass through a 2-flop synchroniser (strum_s, fret_s). All logic uses only the synced values.
- FSM states: IDLE, DEBOUNCE, EMIT, WAIT_RELEASE.
- IDLE:
  - On strum_s=1 and song_running=1: capture onset_time <= song_time, load counter 1, go to DEBOUNCE.
  - strum_s=1 while song_running=0: go to WAIT_RELEASE, no event.
- DEBOUNCE:
  - strum_s=0: return to IDLE (glitch, no event).
  - song_running=0: go to WAIT_RELEASE.
  - Otherwise increment the counter.
  - When counter == DEBOUNCE_CYCLES with strum_s still 1: go to EMIT.
- EMIT (exactly one cycle):
  - If fret_s <= MAX_FRET: match_en=1, fret <= fret_s, match_time <= onset_time, strum_count += 1.
  - Else: reject=1, while fret, match_time and strum_count keep their old values.
  - Next state is always WAIT_RELEASE.
- WAIT_RELEASE:
  - The counter counts consecutive strum_s=0 cycles; any strum_s=1 clears it to 0.
  - When counter reaches RELEASE_CYCLES: clear the counter and go to IDLE.
  - A held button therefore never produces a second event.
- Latency: match_en rises DEBOUNCE_CYCLES+1 cycles after strum_s first samples high, i.e. +2 more from strum_raw.
- match_time equals song_time on the strum_s onset cycle, not the emit cycle.
- fret is sampled in the EMIT cycle, so the fret may settle during debounce.
- Output timing: match_en and reject are registered, never both high, and never high on consecutive cycles. fret and match_time update in the same cycle match_en rises.
- song_time wrap: no special handling; the value is captured verbatim.
- song_running falling mid-debounce aborts without an event. Rising song_running while the button is already held requires a release first.
- Reset asserted mid-operation: immediate clear. After release, the button must be seen low for RELEASE_CYCLES before any event.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, RELEASE_CYCLES=4, MAX_FRET=24.
1. Clean strum: song_running=1, after reset idle-low 10 cycles, fret_raw=7, strum_raw high at song_time=1234 for 20 cycles -> exactly one match_en pulse 7 cycles after the raw edge (2 sync + 4 debounce + 1 emit), fret=7, match_time=1234, strum_count=1.
2. Bounce: strum_raw high 2 cycles, low 1, high 2, low -> no match_en, no reject; then a clean 10-cycle hold -> one event, strum_count=1.
3. Hold and re-strum: hold 50 cycles -> one event. Release 2 cycles then press -> no event (release too short). Release 6 cycles then press -> second event, strum_count=2.
4. Invalid fret: fret_raw=30, clean strum -> reject pulse, match_en=0, fret/match_time unchanged from previous event, strum_count unchanged.
5. Song gating: song_running=0 during strum -> no event. song_running falls during DEBOUNCE -> no event, and a release is required before the next strum arms.
6. Reset mid-debounce: assert rst_n=0 during DEBOUNCE -> all outputs 0 asynchronously. After deassert, with button still high -> no event until 4 low cycles followed by a new press.
